control_fsm: RTL

Multi-cycle control unit for the RV64 datapath. A registered state machine fetches one instruction, decodes opcode/funct3/funct7, and sequences the datapath control strobes: PC load, IR load, register-file write, data-memory read/write, operand/write-back mux selects and ALU operation. It sits beside `cpu` and replaces hard-wired single-cycle control, so the data memory can take a variable number of cycles.

---
 rtl/control_fsm_pkg.sv | 61 ++++++
 rtl/control_fsm_alu_decoder.sv | 36 +++
 rtl/control_fsm.sv | 138 +++++++++++++
 3 files changed

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV64 control unit: state encodings,
// ALU operation codes, opcode/funct3 constants, instruction classes and the
// opcode classifier.
package control_fsm_pkg;

  localparam int WORDSIZE         = 64;  // datapath width, no port depends on it
  localparam int INSTRUCTION_SIZE = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  function automatic instr_class_t classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:      return CLS_R;
      OP_I:      return CLS_I;
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_BRANCH: return CLS_BRANCH;
      default:   return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_alu_decoder.sv
// alu_decoder: combinational ALU operation decode.
// Ports:
//   instr_class - instruction class from the opcode classifier
//   funct3      - instr[14:12]
//   funct7_b5   - instr[30]; SUB/SRA select for R-type, SRA select for I-type
//   alu_op      - ALU operation code
module alu_decoder
  import control_fsm_pkg::*;
(
  input  instr_class_t instr_class,
  input  logic [2:0]   funct3,
  input  logic         funct7_b5,
  output logic [3:0]   alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (instr_class)
      CLS_R, CLS_I: begin
        case (funct3)
          3'b000: alu_op = (instr_class == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      CLS_BRANCH: alu_op = ALU_SUB;
      default:    alu_op = ALU_ADD;  // address generation for load/store
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle control unit for the RV64 datapath.
// Ports:
//   control_fsm_clk/rst_n  - clock, async active-low reset
//   control_fsm_run        - keep executing (sampled in IDLE and at end of instr)
//   control_fsm_instr      - IR contents, valid from DECODE onward
//   control_fsm_alu_zero   - ALU result is zero (branch resolve)
//   control_fsm_dm_ready   - data memory finished the access this cycle
//   control_fsm_pc_we/pc_src/ir_we/rf_we/dm_re/dm_we/alu_src_b/wb_sel/alu_op
//                          - datapath control strobes and selects
//   control_fsm_state      - current state, debug
//   control_fsm_illegal    - sticky illegal opcode/branch flag
//
// state  | meaning
// IDLE   | stopped, waiting for run
// FETCH  | load IR
// DECODE | classify opcode
// EXEC   | ALU op; branches resolve here
// MEM    | data-memory access, waits for dm_ready
// WB     | register write-back, PC+4
// HALT   | illegal instruction, left only by reset
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        control_fsm_clk,
  input  logic                        control_fsm_rst_n,
  input  logic                        control_fsm_run,
  input  logic [INSTRUCTION_SIZE-1:0] control_fsm_instr,
  input  logic                        control_fsm_alu_zero,
  input  logic                        control_fsm_dm_ready,
  output logic                        control_fsm_pc_we,
  output logic                        control_fsm_pc_src,
  output logic                        control_fsm_ir_we,
  output logic                        control_fsm_rf_we,
  output logic                        control_fsm_dm_re,
  output logic                        control_fsm_dm_we,
  output logic                        control_fsm_alu_src_b,
  output logic                        control_fsm_wb_sel,
  output logic [3:0]                  control_fsm_alu_op,
  output logic [2:0]                  control_fsm_state,
  output logic                        control_fsm_illegal
);

  state_t       state_q, state_d;
  instr_class_t cls;
  logic [2:0]   funct3;
  logic [3:0]   dec_op;
  state_t       end_state;
  logic         unused_instr_bits;

  assign cls    = classify(control_fsm_instr[6:0]);
  assign funct3 = control_fsm_instr[14:12];
  assign unused_instr_bits = ^{control_fsm_instr[INSTRUCTION_SIZE-1:31],
                               control_fsm_instr[29:15], control_fsm_instr[11:7]};

  alu_decoder u_alu_decoder (
    .instr_class (cls),
    .funct3      (funct3),
    .funct7_b5   (control_fsm_instr[30]),
    .alu_op      (dec_op)
  );

  assign end_state = control_fsm_run ? ST_FETCH : ST_IDLE;

  always_ff @(posedge control_fsm_clk or negedge control_fsm_rst_n) begin
    if (!control_fsm_rst_n) state_q <= ST_IDLE;
    else                    state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    control_fsm_pc_we     = 1'b0;
    control_fsm_pc_src    = 1'b0;
    control_fsm_ir_we     = 1'b0;
    control_fsm_rf_we     = 1'b0;
    control_fsm_dm_re     = 1'b0;
    control_fsm_dm_we     = 1'b0;
    control_fsm_alu_src_b = 1'b0;
    control_fsm_wb_sel    = 1'b0;
    control_fsm_alu_op    = ALU_ADD;
    case (state_q)
      ST_IDLE:   if (control_fsm_run) state_d = ST_FETCH;
      ST_FETCH: begin
        control_fsm_ir_we = 1'b1;
        state_d           = ST_DECODE;
      end
      ST_DECODE: state_d = (cls == CLS_NONE) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        control_fsm_alu_op    = dec_op;
        control_fsm_alu_src_b = (cls != CLS_R) && (cls != CLS_BRANCH);
        case (cls)
          CLS_R, CLS_I:         state_d = ST_WB;
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
              control_fsm_pc_we  = 1'b1;
              control_fsm_pc_src = (funct3 == F3_BEQ) ? control_fsm_alu_zero
                                                      : ~control_fsm_alu_zero;
              state_d            = end_state;
            end else begin
              state_d = ST_HALT;
            end
          end
          default: state_d = ST_HALT;
        endcase
      end
      ST_MEM: begin
        control_fsm_alu_op    = dec_op;
        control_fsm_alu_src_b = 1'b1;
        control_fsm_dm_re     = (cls == CLS_LOAD);
        control_fsm_dm_we     = (cls == CLS_STORE);
        if (control_fsm_dm_ready) begin
          if (cls == CLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            control_fsm_pc_we = 1'b1;
            state_d           = end_state;
          end
        end
      end
      ST_WB: begin
        control_fsm_alu_op    = dec_op;
        control_fsm_alu_src_b = (cls != CLS_R);
        control_fsm_rf_we     = 1'b1;
        control_fsm_pc_we     = 1'b1;
        control_fsm_wb_sel    = (cls == CLS_LOAD);
        state_d               = end_state;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  assign control_fsm_state   = state_q;
  assign control_fsm_illegal = (state_q == ST_HALT);

endmodule
